found_nonce_fifo: RTL

// - Downstream of SHA block + comparator in the miner top level. Captures each winning {nonce, hash MSW} when a

---
 rtl/miner_pkg.sv | 12 +
 rtl/result_fifo_mem.sv | 26 ++
 rtl/found_nonce_fifo.sv | 95 +++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared types and widths for the miner result path.
package miner_pkg;

  localparam int unsigned NONCE_W    = 32;
  localparam int unsigned HASH_MSW_W = 32;

  typedef struct packed {
    logic [NONCE_W-1:0]    nonce;
    logic [HASH_MSW_W-1:0] hash_msw;
  } result_entry_t;

endpackage

// File: rtl/result_fifo_mem.sv
// Result storage: register array with one synchronous write port and one async read port.
module result_fifo_mem
  import miner_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  result_entry_t     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output result_entry_t     rdata
);

  result_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/found_nonce_fifo.sv
// Captures winning {nonce, hash MSW} per completed attempt and buffers them for the CSR side,
// alongside attempt and dropped-result counters.
module found_nonce_fifo
  import miner_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DROP_W = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  complete,
  input  logic                  found,
  input  logic [NONCE_W-1:0]    nonce,
  input  logic [HASH_MSW_W-1:0] hash_msw,
  input  logic                  pop,
  output logic                  rd_valid,
  output logic [NONCE_W-1:0]    rd_nonce,
  output logic [HASH_MSW_W-1:0] rd_hash,
  output logic [ADDR_W:0]       level,
  output logic                  full,
  output logic [31:0]           hash_cnt,
  output logic [DROP_W-1:0]     drop_cnt
);

  logic          complete_q;
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic          ev, push, empty;
  logic          do_pop, do_push, do_drop;
  result_entry_t wdata, rdata;

  assign ev    = complete & ~complete_q;
  assign push  = ev & found;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign do_drop = push & full & ~do_pop & ~clear;

  assign rd_valid = ~empty;
  assign level    = wr_ptr - rd_ptr;
  assign rd_nonce = rdata.nonce;
  assign rd_hash  = rdata.hash_msw;

  assign wdata.nonce    = nonce;
  assign wdata.hash_msw = hash_msw;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      complete_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hash_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      complete_q <= complete;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        hash_cnt <= '0;
        drop_cnt <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (ev) begin
          hash_cnt <= hash_cnt + 32'd1;
        end
        if (do_drop && (drop_cnt != {DROP_W{1'b1}})) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  result_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

endmodule
